// File: rtl/queue_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : queue_display_pkg
// Description : Shared definitions for the queue display. Holds the active-low
//               7-segment patterns (bit 0 = segment a), the digit count, the
//               digit-index type and the BCD converter state type.
// Revision    : 1.0 - initial release
// ============================================================================
package queue_display_pkg;

    localparam int NUM_DIGITS = 6;

    typedef logic [2:0] digit_idx_t;

    typedef enum logic [0:0] {
        B2B_IDLE  = 1'b0,
        B2B_SHIFT = 1'b1
    } b2b_state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] c_SEG_0     = 7'b1000000;
    localparam logic [6:0] c_SEG_1     = 7'b1111001;
    localparam logic [6:0] c_SEG_2     = 7'b0100100;
    localparam logic [6:0] c_SEG_3     = 7'b0110000;
    localparam logic [6:0] c_SEG_4     = 7'b0011001;
    localparam logic [6:0] c_SEG_5     = 7'b0010010;
    localparam logic [6:0] c_SEG_6     = 7'b0000010;
    localparam logic [6:0] c_SEG_7     = 7'b1111000;
    localparam logic [6:0] c_SEG_8     = 7'b0000000;
    localparam logic [6:0] c_SEG_9     = 7'b0010000;
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = c_SEG_0;
            4'd1:    seg = c_SEG_1;
            4'd2:    seg = c_SEG_2;
            4'd3:    seg = c_SEG_3;
            4'd4:    seg = c_SEG_4;
            4'd5:    seg = c_SEG_5;
            4'd6:    seg = c_SEG_6;
            4'd7:    seg = c_SEG_7;
            4'd8:    seg = c_SEG_8;
            4'd9:    seg = c_SEG_9;
            default: seg = c_SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/queue_display_if.sv
`default_nettype none
// ============================================================================
// Module      : queue_display_if
// Description : Bundle between the ticket service and the queue display.
//               master : drives current_client, total_clients, full
//               slave  : drives seg_n, an_n, waiting, chime (the display)
// Revision    : 1.0 - initial release
// ============================================================================
interface queue_display_if;
    logic [7:0] current_client;
    logic [7:0] total_clients;
    logic       full;
    logic [6:0] seg_n;
    logic [5:0] an_n;
    logic [7:0] waiting;
    logic       chime;

    modport master (
        output current_client, total_clients, full,
        input  seg_n, an_n, waiting, chime
    );

    modport slave (
        input  current_client, total_clients, full,
        output seg_n, an_n, waiting, chime
    );
endinterface
`default_nettype wire

// File: rtl/bin2bcd8.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd8
// Description : Sequential double-dabble 8-bit binary to 3-digit BCD converter.
//               start is accepted while idle; done pulses for one cycle exactly
//               9 cycles after the start cycle, with bcd updated at that point.
//               bcd holds its value between conversions.
// Ports       : clk, rst (async, active-high), start, bin[7:0] in;
//               done, bcd[11:0] {hundreds,tens,units} out
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd8
    import queue_display_pkg::*;
(
    input  wire        clk,
    input  wire        rst,
    input  wire        start,
    input  wire  [7:0] bin,
    output logic       done,
    output logic [11:0] bcd
);

    b2b_state_t  r_state;
    logic [19:0] r_shift;   // {hundreds, tens, units, binary}
    logic [2:0]  r_count;
    logic [19:0] w_adj;

    // Add 3 to any BCD nibble >= 5 before each shift
    always_comb begin
        w_adj = r_shift;
        for (int i = 0; i < 3; i++) begin
            if (r_shift[8 + 4*i +: 4] >= 4'd5) begin
                w_adj[8 + 4*i +: 4] = r_shift[8 + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= B2B_IDLE;
            r_shift <= '0;
            r_count <= '0;
            done    <= 1'b0;
            bcd     <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                B2B_IDLE: begin
                    if (start) begin
                        r_shift <= {12'd0, bin};
                        r_count <= '0;
                        r_state <= B2B_SHIFT;
                    end
                end
                B2B_SHIFT: begin
                    r_shift <= w_adj << 1;
                    r_count <= r_count + 3'd1;
                    if (r_count == 3'd7) begin
                        // Eighth shift: take the result straight from the
                        // adjusted value so done and bcd land together
                        done    <= 1'b1;
                        bcd     <= w_adj[18:7];
                        r_state <= B2B_IDLE;
                    end
                end
                default: r_state <= B2B_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/queue_display.sv
`default_nettype none
// ============================================================================
// Module      : queue_display
// Description : Six-digit multiplexed display of the ticket being served
//               (digits 0-2) and the number waiting (digits 3-5), with
//               leading-zero blanking, a blinking "full" indication on the
//               waiting group and a chime pulse on each new client.
// Ports       : clk, rst (async, active-high);
//               bus (queue_display_if.slave): current_client, total_clients,
//               full in; seg_n, an_n, waiting, chime out
// Revision    : 1.0 - initial release
// ============================================================================
module queue_display
    import queue_display_pkg::*;
#(
    parameter int REFRESH_DIV  = 1000,
    parameter int CHIME_CYCLES = 50000,
    parameter int BLINK_DIV    = 250000
) (
    input  wire            clk,
    input  wire            rst,
    queue_display_if.slave bus
);

    localparam int c_REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int c_CHIME_W = (CHIME_CYCLES > 0) ? $clog2(CHIME_CYCLES + 1) : 1;

    // Sample stage and derived waiting count
    logic [7:0] r_cur_s, r_tot_s, r_waiting;
    logic       r_full_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_s   <= '0;
            r_tot_s   <= '0;
            r_full_s  <= 1'b0;
            r_waiting <= '0;
        end else begin
            r_cur_s   <= bus.current_client;
            r_tot_s   <= bus.total_clients;
            r_full_s  <= bus.full;
            r_waiting <= r_tot_s - r_cur_s;
        end
    end

    // BCD conversion control: restart whenever the source moved away from the
    // last value handed to the converter. The converter is idle again in its
    // done cycle, so a pending change starts right then.
    logic [7:0]  r_conv_cur, r_conv_wait;
    logic        r_busy_cur, r_busy_wait;
    logic        w_start_cur, w_start_wait, w_done_cur, w_done_wait;
    logic [11:0] w_bcd_cur, w_bcd_wait;

    assign w_start_cur  = (r_cur_s   != r_conv_cur)  && (!r_busy_cur  || w_done_cur);
    assign w_start_wait = (r_waiting != r_conv_wait) && (!r_busy_wait || w_done_wait);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conv_cur  <= '0;
            r_conv_wait <= '0;
            r_busy_cur  <= 1'b0;
            r_busy_wait <= 1'b0;
        end else begin
            if (w_start_cur) begin
                r_busy_cur <= 1'b1;
                r_conv_cur <= r_cur_s;
            end else if (w_done_cur) begin
                r_busy_cur <= 1'b0;
            end
            if (w_start_wait) begin
                r_busy_wait <= 1'b1;
                r_conv_wait <= r_waiting;
            end else if (w_done_wait) begin
                r_busy_wait <= 1'b0;
            end
        end
    end

    // The converters' bcd outputs only change on done, so they serve
    // directly as the displayed digit registers.
    bin2bcd8 u_bcd_cur (
        .clk   (clk),
        .rst   (rst),
        .start (w_start_cur),
        .bin   (r_cur_s),
        .done  (w_done_cur),
        .bcd   (w_bcd_cur)
    );

    bin2bcd8 u_bcd_wait (
        .clk   (clk),
        .rst   (rst),
        .start (w_start_wait),
        .bin   (r_waiting),
        .done  (w_done_wait),
        .bcd   (w_bcd_wait)
    );

    // Digit scan, blink phase and digit selection
    logic [c_REF_W-1:0]   r_refresh;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_blink;
    digit_idx_t           r_idx;
    logic [5:0]           r_an_n;
    logic [6:0]           r_seg_n;
    logic                 w_grp_wait, w_blank;
    logic [11:0]          w_bcd;
    logic [3:0]           w_digit;

    assign w_grp_wait = (r_idx >= digit_idx_t'(3));

    always_comb begin
        w_bcd   = w_grp_wait ? w_bcd_wait : w_bcd_cur;
        w_digit = 4'd0;
        w_blank = 1'b0;
        case (r_idx)
            3'd0, 3'd3: w_digit = w_bcd[3:0];
            3'd1, 3'd4: begin
                w_digit = w_bcd[7:4];
                w_blank = (w_bcd[11:4] == 8'd0);
            end
            3'd2, 3'd5: begin
                w_digit = w_bcd[11:8];
                w_blank = (w_bcd[11:8] == 4'd0);
            end
            default: w_blank = 1'b1;
        endcase
        if (w_grp_wait && r_full_s && r_blink) begin
            w_blank = 1'b1;
        end
    end

    // Outputs are registered so they sit at all-off during reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh   <= '0;
            r_idx       <= '0;
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
            r_an_n      <= '1;
            r_seg_n     <= c_SEG_BLANK;
        end else begin
            if (r_refresh == c_REF_W'(REFRESH_DIV - 1)) begin
                r_refresh <= '0;
                r_idx     <= (r_idx == digit_idx_t'(NUM_DIGITS - 1)) ? '0 : r_idx + 3'd1;
            end else begin
                r_refresh <= r_refresh + c_REF_W'(1);
            end
            if (r_blink_cnt == c_BLINK_W'(BLINK_DIV - 1)) begin
                r_blink_cnt <= '0;
                r_blink     <= ~r_blink;
            end else begin
                r_blink_cnt <= r_blink_cnt + c_BLINK_W'(1);
            end
            r_an_n  <= w_blank ? 6'b111111 : ~(6'd1 << r_idx);
            r_seg_n <= w_blank ? c_SEG_BLANK : seg_encode(w_digit);
        end
    end

    // Chime: r_valid marks that the sample stage holds a real sample,
    // r_primed that r_prev_cur does too, so the first sample never chimes.
    logic                 r_valid, r_primed;
    logic [7:0]           r_prev_cur;
    logic [c_CHIME_W-1:0] r_chime_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_primed    <= 1'b0;
            r_prev_cur  <= '0;
            r_chime_cnt <= '0;
        end else begin
            r_valid    <= 1'b1;
            r_primed   <= r_valid;
            r_prev_cur <= r_cur_s;
            if (r_primed && (r_cur_s != r_prev_cur)) begin
                r_chime_cnt <= c_CHIME_W'(CHIME_CYCLES);
            end else if (r_chime_cnt != '0) begin
                r_chime_cnt <= r_chime_cnt - c_CHIME_W'(1);
            end
        end
    end

    assign bus.seg_n   = r_seg_n;
    assign bus.an_n    = r_an_n;
    assign bus.waiting = r_waiting;
    assign bus.chime   = (r_chime_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_queue_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_queue_display
// Description : Self-checking bench for queue_display. A reference model keeps
//               the per-cycle input history since the last reset release and
//               derives waiting, chime and the scanned display from it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_queue_display;

    localparam int REF   = 4;
    localparam int CHIME = 8;
    localparam int BLINK = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    queue_display_if qif();

    queue_display #(
        .REFRESH_DIV  (REF),
        .CHIME_CYCLES (CHIME),
        .BLINK_DIV    (BLINK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (qif)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: inputs seen at each rising edge since reset release
    int tb_cyc;
    int cur_h[$];
    int tot_h[$];
    int full_h[$];
    logic [6:0] seg_tbl [10];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tb_cyc = 0;
            cur_h.delete();
            tot_h.delete();
            full_h.delete();
        end else begin
            cur_h.push_back(int'(qif.current_client));
            tot_h.push_back(int'(qif.total_clients));
            full_h.push_back(int'(qif.full));
            tb_cyc++;
        end
    end

    // Waiting in cycle m reflects the inputs seen two edges earlier
    function automatic logic [7:0] exp_waiting(int m);
        if (m < 2) return 8'd0;
        return 8'((tot_h[m-2] - cur_h[m-2] + 256) % 256);
    endfunction

    // Chime in cycle m: some change of current_client between consecutive
    // samples c-1 -> c (c >= 1) with m in [c+2, c+1+CHIME]
    function automatic logic exp_chime(int m);
        int lo;
        lo = (m - 1 - CHIME < 1) ? 1 : m - 1 - CHIME;
        for (int c = lo; c <= m - 2; c++) begin
            if (cur_h[c] != cur_h[c-1]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Display in cycle m for stable shown values vc / vw
    function automatic void exp_disp(int m, int vc, int vw,
                                     output logic [5:0] an, output logic [6:0] seg);
        int d, v, pos, dig;
        logic blank;
        an  = 6'b111111;
        seg = 7'b1111111;
        if (m < 1) return;
        d   = ((m - 1) / REF) % 6;
        v   = (d < 3) ? vc : vw;
        pos = d % 3;
        dig = (pos == 0) ? v % 10 : (pos == 1) ? (v / 10) % 10 : v / 100;
        blank = (pos == 2 && v < 100) || (pos == 1 && v < 10);
        if (d >= 3 && m >= 2 && full_h[m-2] != 0 && ((m - 1) / BLINK) % 2 == 1)
            blank = 1'b1;
        if (!blank) begin
            an  = ~(6'd1 << d);
            seg = seg_tbl[dig];
        end
    endfunction

    task automatic drive(input int c, input int t, input int f);
        qif.current_client = 8'(c);
        qif.total_clients  = 8'(t);
        qif.full           = f[0];
    endtask

    // Track waiting/chime each cycle; with disp set also the scanned digits
    task automatic test_outputs(input int vc, input int vw, input int n, input bit disp);
        logic [5:0] ean;
        logic [6:0] eseg;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (qif.waiting !== exp_waiting(tb_cyc)) begin
                errors++;
                $display("FAIL waiting cyc=%0d got=%0d exp=%0d", tb_cyc, qif.waiting, exp_waiting(tb_cyc));
            end
            checks++;
            if (qif.chime !== exp_chime(tb_cyc)) begin
                errors++;
                $display("FAIL chime cyc=%0d got=%b exp=%b", tb_cyc, qif.chime, exp_chime(tb_cyc));
            end
            if (disp) begin
                exp_disp(tb_cyc, vc, vw, ean, eseg);
                checks++;
                if (qif.an_n !== ean || qif.seg_n !== eseg) begin
                    errors++;
                    $display("FAIL display cyc=%0d got an_n=%b seg_n=%b exp an_n=%b seg_n=%b",
                             tb_cyc, qif.an_n, qif.seg_n, ean, eseg);
                end
            end
        end
    endtask

    task automatic test_reset();
        drive(0, 0, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (qif.an_n !== 6'b111111) begin
            errors++; $display("FAIL reset_an_n got=%b exp=111111", qif.an_n);
        end
        checks++;
        if (qif.seg_n !== 7'b1111111) begin
            errors++; $display("FAIL reset_seg_n got=%b exp=1111111", qif.seg_n);
        end
        checks++;
        if (qif.chime !== 1'b0) begin
            errors++; $display("FAIL reset_chime got=%b exp=0", qif.chime);
        end
        checks++;
        if (qif.waiting !== 8'd0) begin
            errors++; $display("FAIL reset_waiting got=%0d exp=0", qif.waiting);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_zero();
        test_outputs(0, 0, 40, 1'b1);
    endtask

    task automatic test_waiting_update();
        drive(0, 20, 0);
        test_outputs(0, 20, 11, 1'b0);
        test_outputs(0, 20, 30, 1'b1);
    endtask

    task automatic test_chime();
        int highs = 0;
        drive(1, 20, 0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            checks++;
            if (qif.chime !== exp_chime(tb_cyc)) begin
                errors++;
                $display("FAIL chime_single cyc=%0d got=%b exp=%b", tb_cyc, qif.chime, exp_chime(tb_cyc));
            end
            highs += int'(qif.chime);
        end
        checks++;
        if (highs != CHIME) begin
            errors++; $display("FAIL chime_length got=%0d exp=%0d", highs, CHIME);
        end
    endtask

    task automatic test_chime_restart();
        int highs = 0;
        drive(2, 20, 0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            checks++;
            if (qif.chime !== exp_chime(tb_cyc)) begin
                errors++;
                $display("FAIL chime_restart cyc=%0d got=%b exp=%b", tb_cyc, qif.chime, exp_chime(tb_cyc));
            end
            highs += int'(qif.chime);
            if (i == 5) drive(3, 20, 0);   // during the 4th high cycle
        end
        checks++;
        if (highs != CHIME + 5) begin
            errors++; $display("FAIL chime_restart_length got=%0d exp=%0d", highs, CHIME + 5);
        end
        test_outputs(3, 17, 30, 1'b1);
    endtask

    task automatic test_wrap();
        drive(250, 3, 0);
        test_outputs(0, 0, 14, 1'b0);
        test_outputs(250, 9, 30, 1'b1);
    endtask

    task automatic test_back_to_back();
        drive(250, 100, 0);
        test_outputs(0, 0, 3, 1'b0);
        drive(250, 123, 0);                // lands mid-conversion of 106
        test_outputs(0, 0, 24, 1'b0);
        test_outputs(250, 129, 30, 1'b1);
    endtask

    task automatic test_blink();
        drive(5, 12, 1);
        test_outputs(0, 0, 14, 1'b0);
        test_outputs(5, 7, 80, 1'b1);
        drive(5, 12, 0);
        test_outputs(0, 0, 3, 1'b0);
        test_outputs(5, 7, 30, 1'b1);
    endtask

    task automatic test_random();
        int c, t, f;
        for (int k = 0; k < 6; k++) begin
            c = int'($urandom_range(0, 255));
            t = int'($urandom_range(0, 255));
            f = int'($urandom_range(0, 1));
            drive(c, t, f);
            test_outputs(0, 0, 14, 1'b0);
            test_outputs(c, (t - c + 256) % 256, 30, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        drive(77, 90, 0);
        repeat (4) @(negedge clk);         // conversions running, chime high
        #2 rst = 1'b1;
        #1;
        checks++;
        if (qif.an_n !== 6'b111111 || qif.seg_n !== 7'b1111111) begin
            errors++;
            $display("FAIL midreset_display got an_n=%b seg_n=%b exp 111111/1111111", qif.an_n, qif.seg_n);
        end
        checks++;
        if (qif.chime !== 1'b0 || qif.waiting !== 8'd0) begin
            errors++;
            $display("FAIL midreset_chime_waiting got chime=%b waiting=%0d exp 0/0", qif.chime, qif.waiting);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // Converters restart from zero: first 10 cycles still show "  0"/"  0"
        test_outputs(0, 0, 10, 1'b1);
        test_outputs(0, 0, 6, 1'b0);
        test_outputs(77, 13, 30, 1'b1);
    endtask

    initial begin
        seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        drive(0, 0, 0);
        @(negedge clk);
        test_reset();
        test_idle_zero();
        test_waiting_update();
        test_chime();
        test_chime_restart();
        test_wrap();
        test_back_to_back();
        test_blink();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
